// File: rtl/wb_writeback_pkg.sv
// wb_writeback_pkg: shared constants and load-lane extraction for the writeback stage
package wb_writeback_pkg;
   localparam int DEF_REGFILE_SIZE = 32;
   localparam int DEF_FIFO_DEPTH = 2;
   localparam int DEF_DATA_W = 32;
   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
   // Big-endian lanes: byte 0 sits in bits 31:24; reserved size 3 behaves as word.
   function automatic logic [31:0] ld_extract(input logic [31:0] w, input logic [1:0] size,
                                              input logic sext, input logic [1:0] boff);
      logic [7:0] b;
      logic [15:0] h;
      b = 8'(w >> {~boff, 3'b000});
      h = boff[1] ? w[15:0] : w[31:16];
      return size == MEM_SIZE_BYTE ? {{24{sext & b[7]}}, b} :
             size == MEM_SIZE_HALF ? {{16{sext & h[15]}}, h} : w;
   endfunction
endpackage

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: synchronous buffer of extracted load returns awaiting the write port
module wb_load_fifo #(
   parameter int DEPTH = 2,
   parameter int AW = 5,
   parameter int DW = 32,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic [AW-1:0] push_adr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [AW-1:0] head_adr,
   output logic [DW-1:0] head_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [AW-1:0] adr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] rd, wr;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_push = push & (!full | pop);
   assign do_pop = pop & !empty;
   assign head_adr = adr_q[rd];
   assign head_data = data_q[rd];
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
         if (do_pop) rd <= rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge CLK) begin
      if (do_push) begin
         adr_q[wr] <= push_adr;
         data_q[wr] <= push_data;
      end
   end
endmodule

// File: rtl/wb_writeback.sv
// wb_writeback: merges ALU results and buffered load returns onto the register-file write port
module wb_writeback
   import wb_writeback_pkg::*;
#(
   parameter int REGFILE_SIZE = DEF_REGFILE_SIZE,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DATA_W = DEF_DATA_W,
   localparam int AW = $clog2(REGFILE_SIZE)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    ex_valid,
   output logic                    ex_ready,
   input  logic [AW-1:0]           ex_wadr,
   input  logic [DATA_W-1:0]       ex_wdata,
   input  logic                    ld_issue,
   input  logic [AW-1:0]           ld_issue_adr,
   input  logic                    mem_valid,
   output logic                    mem_ready,
   input  logic [AW-1:0]           mem_wadr,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic [1:0]              mem_size,
   input  logic                    mem_sext,
   input  logic [1:0]              mem_boff,
   output logic                    WE,
   output logic [AW-1:0]           Wadr,
   output logic [DATA_W-1:0]       Wdata,
   output logic [REGFILE_SIZE-1:0] busy
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic [AW-1:0] head_adr, sel_adr;
   logic [DATA_W-1:0] head_data, sel_data;
   logic [CW-1:0] count;
   logic full, empty, ex_take, deq, enq, sel;
   logic [REGFILE_SIZE-1:0] busy_nxt;
   wb_load_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW), .DW(DATA_W)) u_fifo (
      .CLK(CLK),
      .RST(RST),
      .push(enq),
      .push_adr(mem_wadr),
      .push_data(ld_extract(mem_rdata, mem_size, mem_sext, mem_boff)),
      .pop(deq),
      .head_adr(head_adr),
      .head_data(head_data),
      .full(full),
      .empty(empty),
      .count(count)
   );
   assign ex_ready = !full;
   assign mem_ready = !full;
   assign ex_take = ex_valid & ex_ready;
   // A full buffer forces ex_ready low, so the head drains on those cycles.
   assign deq = !empty & !ex_take;
   assign enq = mem_valid & mem_ready;
   assign sel = ex_take | deq;
   assign sel_adr = ex_take ? ex_wadr : head_adr;
   assign sel_data = ex_take ? ex_wdata : head_data;
   // Clear before set so a same-cycle reissue to the draining register stays busy.
   always_comb begin
      busy_nxt = busy & ~(deq ? REGFILE_SIZE'(1) << head_adr : '0);
      busy_nxt = busy_nxt | (ld_issue ? REGFILE_SIZE'(1) << ld_issue_adr : '0);
      busy_nxt[0] = 1'b0;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         WE <= 1'b0;
         Wadr <= '0;
         Wdata <= '0;
         busy <= '0;
      end else begin
         WE <= sel & |sel_adr;
         if (sel) begin
            Wadr <= sel_adr;
            Wdata <= sel_data;
         end
         busy <= busy_nxt;
      end
   end
endmodule

// File: tb/tb_wb_writeback.sv
// tb_wb_writeback: directed stimulus with per-source expected-write queues checked on every WE
module tb_wb_writeback;
   logic CLK = 0, RST = 0;
   logic ex_valid = 0, ld_issue = 0, mem_valid = 0, mem_sext = 0;
   logic [4:0] ex_wadr = 0, ld_issue_adr = 0, mem_wadr = 0;
   logic [31:0] ex_wdata = 0, mem_rdata = 0;
   logic [1:0] mem_size = 0, mem_boff = 0;
   logic ex_ready, mem_ready, WE;
   logic [4:0] Wadr;
   logic [31:0] Wdata, busy;
   logic [36:0] ex_q[$], ld_q[$];
   int n_tests = 0, n_fail = 0;

   wb_writeback dut (
      .CLK(CLK), .RST(RST),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wadr(ex_wadr), .ex_wdata(ex_wdata),
      .ld_issue(ld_issue), .ld_issue_adr(ld_issue_adr),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wadr(mem_wadr), .mem_rdata(mem_rdata),
      .mem_size(mem_size), .mem_sext(mem_sext), .mem_boff(mem_boff),
      .WE(WE), .Wadr(Wadr), .Wdata(Wdata), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ex_valid = 0;
      mem_valid = 0;
      ld_issue = 0;
   endtask

   task automatic drive_ex(input logic [4:0] a, input logic [31:0] d);
      ex_valid = 1;
      ex_wadr = a;
      ex_wdata = d;
   endtask

   task automatic drive_mem(input logic [4:0] a, input logic [31:0] w, input logic [1:0] sz,
                            input logic sx, input logic [1:0] bo);
      mem_valid = 1;
      mem_wadr = a;
      mem_rdata = w;
      mem_size = sz;
      mem_sext = sx;
      mem_boff = bo;
   endtask

   // Each source keeps its own order; the ALU may overtake buffered loads.
   always @(negedge CLK) begin
      if (RST && WE) begin
         if (ex_q.size() != 0 && {Wadr, Wdata} == ex_q[0])
            chk("wr_ex", {Wadr, Wdata}, ex_q.pop_front());
         else if (ld_q.size() != 0)
            chk("wr_ld", {Wadr, Wdata}, ld_q.pop_front());
         else
            chk("spurious_we", WE, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {logic [1:0] sz; logic sx; logic [1:0] bo; logic [31:0] exp;} ld_case_t;
   ld_case_t cases[6] = '{
      '{2'd0, 1'b1, 2'd0, 32'hFFFF_FF80},
      '{2'd1, 1'b0, 2'd2, 32'h0000_1234},
      '{2'd1, 1'b1, 2'd1, 32'hFFFF_80FF},
      '{2'd0, 1'b0, 2'd1, 32'h0000_00FF},
      '{2'd0, 1'b1, 2'd3, 32'h0000_0034},
      '{2'd3, 1'b1, 2'd2, 32'h80FF_1234}
   };

   initial begin
      tick();
      tick();
      chk("rst_we", WE, 0);
      chk("rst_wadr", Wadr, 0);
      chk("rst_wdata", Wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ex_ready", ex_ready, 1);
      chk("rst_mem_ready", mem_ready, 1);
      RST = 1;
      tick();
      // Byte load with scoreboard set/clear, then the extraction table
      ld_issue = 1;
      ld_issue_adr = 9;
      tick();
      idle();
      chk("busy_set9", busy, 32'h200);
      for (int i = 0; i < 6; i++) begin
         drive_mem(5'(9 + i), 32'h80FF_1234, cases[i].sz, cases[i].sx, cases[i].bo);
         ld_q.push_back({5'(9 + i), cases[i].exp});
         tick();
         idle();
         chk("ld_no_early_we", WE, 0);
         tick();
         chk("ld_we", WE, 1);
         chk("ld_wadr", Wadr, 9 + i);
         chk("ld_wdata", Wdata, cases[i].exp);
         if (i == 0) chk("busy_clr9", busy, 0);
      end
      // Collision: ALU first, load the cycle after
      drive_ex(3, 32'h11);
      drive_mem(4, 32'h22, 2'd2, 0, 0);
      ex_q.push_back({5'd3, 32'h11});
      ld_q.push_back({5'd4, 32'h22});
      tick();
      idle();
      chk("col_wadr1", Wadr, 3);
      chk("col_wdata1", Wdata, 32'h11);
      tick();
      chk("col_wadr2", Wadr, 4);
      chk("col_wdata2", Wdata, 32'h22);
      tick();
      chk("col_idle_we", WE, 0);
      // Full buffer: ALU keeps winning until the buffer fills
      drive_ex(11, 32'hA1);
      drive_mem(12, 32'hB1, 2'd2, 0, 0);
      ex_q.push_back({5'd11, 32'hA1});
      ld_q.push_back({5'd12, 32'hB1});
      tick();
      drive_ex(13, 32'hA2);
      drive_mem(14, 32'hB2, 2'd2, 0, 0);
      ex_q.push_back({5'd13, 32'hA2});
      ld_q.push_back({5'd14, 32'hB2});
      chk("full_mem_ready_before", mem_ready, 1);
      tick();
      drive_ex(15, 32'hA3);
      drive_mem(16, 32'hB3, 2'd2, 0, 0);
      #1;
      chk("full_ex_ready", ex_ready, 0);
      chk("full_mem_ready", mem_ready, 0);
      tick();
      chk("full_head_wadr", Wadr, 12);
      chk("full_head_wdata", Wdata, 32'hB1);
      chk("after_full_ex_ready", ex_ready, 1);
      chk("after_full_mem_ready", mem_ready, 1);
      ex_q.push_back({5'd15, 32'hA3});
      ld_q.push_back({5'd16, 32'hB3});
      tick();
      idle();
      chk("full_ex3_wadr", Wadr, 15);
      #1;
      chk("refull_mem_ready", mem_ready, 0);
      tick();
      chk("drain_wadr14", Wadr, 14);
      tick();
      chk("drain_wadr16", Wadr, 16);
      chk("drained_mem_ready", mem_ready, 1);
      tick();
      // Zero register
      drive_ex(0, 32'h55);
      ld_issue = 1;
      ld_issue_adr = 0;
      tick();
      idle();
      chk("zero_ex_we", WE, 0);
      chk("zero_busy", busy, 0);
      drive_mem(0, 32'h66, 2'd2, 0, 0);
      tick();
      idle();
      tick();
      chk("zero_ld_we", WE, 0);
      // Scoreboard: ALU writes leave busy alone, same-cycle set beats clear
      ld_issue = 1;
      ld_issue_adr = 5;
      tick();
      idle();
      drive_ex(5, 32'h77);
      ex_q.push_back({5'd5, 32'h77});
      tick();
      idle();
      chk("alu_keeps_busy", busy, 32'h20);
      drive_mem(5, 32'h88, 2'd2, 0, 0);
      ld_q.push_back({5'd5, 32'h88});
      tick();
      idle();
      ld_issue = 1;
      ld_issue_adr = 5;
      tick();
      idle();
      chk("setclr_wadr", Wadr, 5);
      chk("set_wins", busy, 32'h20);
      drive_mem(5, 32'h99, 2'd2, 0, 0);
      ld_q.push_back({5'd5, 32'h99});
      tick();
      idle();
      tick();
      chk("busy_cleared5", busy, 0);
      // Reset mid-operation with two loads buffered
      ld_issue = 1;
      ld_issue_adr = 8;
      tick();
      ld_issue_adr = 9;
      tick();
      idle();
      drive_ex(1, 32'hC1);
      drive_mem(8, 32'hD1, 2'd2, 0, 0);
      ex_q.push_back({5'd1, 32'hC1});
      tick();
      drive_ex(2, 32'hC2);
      drive_mem(9, 32'hD2, 2'd2, 0, 0);
      ex_q.push_back({5'd2, 32'hC2});
      tick();
      idle();
      chk("pre_rst_busy", busy, 32'h300);
      chk("pre_rst_mem_ready", mem_ready, 0);
      @(negedge CLK);
      #1;
      RST = 0;
      #1;
      chk("async_rst_we", WE, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_mem_ready", mem_ready, 1);
      tick();
      RST = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_stale", WE, 0);
      end
      chk("ex_q_empty", ex_q.size(), 0);
      chk("ld_q_empty", ld_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
